// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port 32x32 data memory: round-robin
// between core (port 0) and DMA/debug (port 1), with a bounded port-1 burst lock.
module dmem_port_arbiter #(
   parameter int DEPTH    = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,
   input  logic        lock1,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic        dbg_state
);

   // Handshake: a request transfers in the cycle where reqN_valid & reqN_ready;
   // the requester holds its request fields stable while valid & !ready, and the
   // single-cycle response (rspN_valid) follows on the next posedge.

   localparam int            CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_LOCK);
   localparam logic [31:0]   DEPTH_C = 32'(DEPTH);

   typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} state_t;

   state_t        state, state_nx;
   logic          rr_last, rr_last_nx;
   logic [CW-1:0] lock_cnt, lock_cnt_nx;
   logic          grant0, grant1;
   logic          rr_eff;
   logic          g_we;
   logic [31:0]   g_addr, g_wdata;
   logic          in_range;
   logic [31:0]   rd_val;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= ARB;
         rr_last  <= 1'b1;
         lock_cnt <= '0;
      end else begin
         state    <= state_nx;
         rr_last  <= rr_last_nx;
         lock_cnt <= lock_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      rr_last_nx  = rr_last;
      grant0      = 1'b0;
      grant1      = 1'b0;
      rr_eff      = rr_last;
      // Nothing is accepted while reset is held, so reset never writes memory.
      if (RST) begin
         if (state == LOCK1 && req1_valid && lock1 && lock_cnt < MAX_C) begin
            grant1      = 1'b1;
            lock_cnt_nx = lock_cnt + CW'(1);
         end else begin
            if (state == LOCK1) begin
               // Leaving a burst arbitrates as if port 1 just won, so port 0 goes next.
               state_nx    = ARB;
               lock_cnt_nx = '0;
               rr_eff      = 1'b1;
            end
            if (req0_valid && req1_valid) begin
               grant0 = rr_eff;
               grant1 = !rr_eff;
            end else begin
               grant0 = req0_valid;
               grant1 = req1_valid;
            end
            if (state == ARB && grant1 && lock1) begin
               state_nx    = LOCK1;
               lock_cnt_nx = CW'(1);
            end
         end
         if (grant0)
            rr_last_nx = 1'b0;
         else if (grant1)
            rr_last_nx = 1'b1;
      end
   end

   always_comb begin
      g_we    = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      if (grant0) begin
         g_we    = req0_we;
         g_addr  = req0_addr;
         g_wdata = req0_wdata;
      end else if (grant1) begin
         g_we    = req1_we;
         g_addr  = req1_addr;
         g_wdata = req1_wdata;
      end
   end

   assign in_range   = (g_addr < DEPTH_C);
   assign rd_val     = (in_range && !g_we) ? mem_rd : '0;
   assign mem_we     = g_we && in_range;
   assign mem_a      = g_addr;
   assign mem_wd     = g_wdata;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign dbg_state  = (state == LOCK1);

   // rdata/err only move on a grant; they hold while rsp_valid is low.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         rsp0_valid <= grant0;
         rsp1_valid <= grant1;
         if (grant0) begin
            rsp0_rdata <= rd_val;
            rsp0_err   <= !in_range;
         end
         if (grant1) begin
            rsp1_rdata <= rd_val;
            rsp1_err   <= !in_range;
         end
      end
   end

endmodule
